spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Byte-oriented SPI master (mode 0, MSB first) driving the accelerometer Pmod pins `accel_pmod_cs`, `accel_pmod_mosi`, `accel_pmod_sck` and `accel_pmod_miso` at the top level.
- Replaces the constant defaults currently tied on those pins.
- Accepts command/data bytes on a valid/ready stream and returns each received MISO byte on a valid/ready stream.
- Downstream of the UART command path; it is the consumer that turns host bytes into ADXL362 register transactions.

Parameters:
- CLK_DIV, 50, clk cycles per SCK half-period (100 MHz / (2*50) = 1 MHz SCK); must be >= 2.
- CS_SETUP_CYCLES, 10, clk cycles from cs falling to first SCK rising edge; must be >= 1.
- CS_HOLD_CYCLES, 10, clk cycles from last SCK falling edge to cs rising.
- CS_IDLE_CYCLES, 20, minimum clk cycles cs stays high between transactions.

Ports:
- clk  in  1  system clock (clk_100 at top)
- reset  in  1  synchronous, active-low reset (0 = reset asserted)
- tx_data  in  8  byte to shift out
- tx_valid  in  1  tx_data valid
- tx_last  in  1  byte is final in transaction; cs deasserts after it
- tx_ready  out  1  byte accepted when tx_valid && tx_ready
- rx_data  out  8  byte sampled from MISO
- rx_valid  out  1  rx_data valid; held until rx_ready
- rx_ready  in  1  consumer accepts rx_data
- busy  out  1  high whenever state != IDLE
- spi_cs  out  1  chip select, active-low
- spi_sck  out  1  serial clock, idles low
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in

Behaviour:
- Reset (reset==0 on a rising clk edge), all outputs:
  - spi_cs=1, spi_sck=0, spi_mosi=0.
  - tx_ready=0, rx_valid=0, rx_data=0, busy=0.
  - State goes to IDLE; any in-flight transaction is abandoned immediately, with cs high on the next cycle.
- States: IDLE, CS_SETUP, SHIFT, BYTE_DONE, CS_HOLD, CS_IDLE.
- IDLE:
  - tx_ready=1 and rx_valid is low; a pending rx byte blocks IDLE, so it is never entered with one.
  - On handshake: latch tx_data into the shift register and tx_last into last_q.
  - Next cycle: spi_cs=0, spi_mosi=bit7, enter CS_SETUP.
- CS_SETUP: count CS_SETUP_CYCLES, then enter SHIFT with spi_sck still low.
- SHIFT:
  - Half-period counter 0..CLK_DIV-1; on wrap, toggle spi_sck.
  - Rising edge (sck 0->1): sample spi_miso into the rx shift register LSB.
  - Falling edge (sck 1->0): shift the tx register left and drive the next bit on spi_mosi.
  - After the 8th falling edge (16 toggles), enter BYTE_DONE; spi_mosi holds its last value.
- BYTE_DONE:
  - rx_data=assembled byte, rx_valid=1, held until rx_ready.
  - Once rx accepted (or on the same cycle if rx_ready=1):
    - last_q=1 -> CS_HOLD.
    - last_q=0 -> tx_ready=1; on tx handshake, load the byte and return to SHIFT (cs stays low, no setup delay).
    - Stall indefinitely in BYTE_DONE with cs low and sck low while tx_valid=0.
- CS_HOLD: count CS_HOLD_CYCLES, then spi_cs=1 -> CS_IDLE.
- CS_IDLE: count CS_IDLE_CYCLES, then IDLE.
- tx_ready is high only in IDLE and in BYTE_DONE after rx accepted; tx_data is ignored at all other times.
- Mode-0 timing: MOSI is stable >= CLK_DIV cycles before each rising edge; MISO is sampled exactly on the cycle sck rises.
- Single-byte latency (tx accept -> rx_valid): 1 + CS_SETUP_CYCLES + 16*CLK_DIV + 1 cycles.
- All counters are sized $clog2 of max(param)+1; no counter wraps except the half-period counter.

Decomposition:
- Package spi_pkg:
  - spi_state_t enum.
  - ADXL362 constants: CMD_WRITE=8'h0A, CMD_READ=8'h0B, REG_DEVID_AD=8'h00, DEVID_AD_VALUE=8'hAD.
- Sub-module spi_sck_gen:
  - Half-period counter and sck register.
  - Emits one-cycle rise_pulse/fall_pulse strobes; enabled only in SHIFT.

Test Plan (CLK_DIV=2, CS_SETUP=CS_HOLD=2, CS_IDLE=4 for speed):
- Reset mid-SHIFT of byte 0xA5 -> cs=1, sck=0, busy=0 the cycle after reset; no rx_valid afterwards.
- MOSI->MISO loopback, single byte 0x5A with tx_last=1 -> rx_data=0x5A, rx_valid exactly 1+2+32+1=36 cycles after accept; cs rises 2 cycles after rx accepted.
- ADXL362 slave model, bytes 0x0B, 0x00, 0xFF (last on 3rd) -> MOSI decodes 0x0B,0x00,0xFF; rx bytes ignore, ignore, 0xAD; cs stays low across all 24 sck rises.
- rx_ready held low 10 cycles after byte 1 of 2 -> spi_sck frozen low, cs low, tx_ready=0 during stall; transfer resumes after accept.
- tx_valid gap of 7 cycles between bytes 1 and 2 (tx_last=0) -> cs stays low through gap; sck has exactly 16 toggles per byte.
- Back-to-back single-byte transactions -> cs high for >= 4 cycles between them; tx_ready low during CS_HOLD/CS_IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and ADXL362 constants for the accelerometer SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CS_SETUP  = 3'd1,
        SHIFT     = 3'd2,
        BYTE_DONE = 3'd3,
        CS_HOLD   = 3'd4,
        CS_IDLE   = 3'd5
    } spi_state_t;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] REG_DEVID_AD   = 8'h00;
    localparam logic [7:0] DEVID_AD_VALUE = 8'hAD;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: half-period counter plus rise/fall strobes, parked low when disabled.
module spi_sck_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int HW = $clog2(CLK_DIV);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          sck_q, sck_d;
    logic          wrap_s;

    // Half-period count and toggle decision
    always_comb begin
        wrap_s = en_i && (hcnt_q == HW'(CLK_DIV - 1));
        hcnt_d = '0;
        sck_d  = 1'b0;
        if (en_i) begin
            if (wrap_s) begin
                hcnt_d = '0;
                sck_d  = ~sck_q;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
                sck_d  = sck_q;
            end
        end else begin
            hcnt_d = '0;
            sck_d  = 1'b0;
        end
    end

    // Counter and SCK registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt_q <= '0;
            sck_q  <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            sck_q  <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign rise_o = wrap_s && !sck_q;
    assign fall_o = wrap_s && sck_q;

endmodule

// File: rtl/spi_master.sv
// Byte-stream SPI master (mode 0, MSB first) for the ADXL362 Pmod.
// Timing parameters other than CLK_DIV are expected to be >= 1.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV         = 50,
    parameter int CS_SETUP_CYCLES = 10,
    parameter int CS_HOLD_CYCLES  = 10,
    parameter int CS_IDLE_CYCLES  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int CW = $clog2(max3(CS_SETUP_CYCLES, CS_HOLD_CYCLES, CS_IDLE_CYCLES) + 1);

    spi_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          last_q, last_d;
    logic          cs_q, cs_d;
    logic          mosi_q, mosi_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_acc_q, rx_acc_d;
    logic          tx_ready_q, tx_ready_d;
    logic          busy_q, busy_d;
    logic          tx_fire_s, rx_fire_s, rise_s, fall_s, sck_s;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q == SHIFT),
        .sck_o  (sck_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // Next-state and datapath decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        rx_valid_d = rx_valid_q;
        rx_acc_d   = rx_acc_q;
        tx_fire_s  = tx_valid && tx_ready_q;
        rx_fire_s  = rx_valid_q && rx_ready;

        case (state_q)
            IDLE: begin
                if (tx_fire_s) begin
                    tx_sh_d = tx_data;
                    last_d  = tx_last;
                    mosi_d  = tx_data[7];
                    bit_d   = 3'd0;
                    cs_d    = 1'b0;
                    state_d = CS_SETUP;
                end else begin
                    cs_d = 1'b1;
                end
            end
            // First cycle here is the cs-fall cycle, then CS_SETUP_CYCLES more
            CS_SETUP: begin
                if (cnt_q == CW'(CS_SETUP_CYCLES)) begin
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (rise_s) begin
                    rx_sh_d = {rx_sh_q[6:0], spi_miso};
                end else begin
                    rx_sh_d = rx_sh_q;
                end
                if (fall_s) begin
                    if (bit_q == 3'd7) begin
                        state_d  = BYTE_DONE;
                        rx_acc_d = 1'b0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        mosi_d  = tx_sh_q[6];
                    end
                end else begin
                    bit_d = bit_q;
                end
            end
            // Publish the byte, wait for the consumer, then either chain or close
            BYTE_DONE: begin
                if (rx_acc_q) begin
                    if (tx_fire_s) begin
                        tx_sh_d = tx_data;
                        last_d  = tx_last;
                        mosi_d  = tx_data[7];
                        bit_d   = 3'd0;
                        state_d = SHIFT;
                    end else begin
                        state_d = BYTE_DONE;
                    end
                end else if (rx_fire_s) begin
                    rx_valid_d = 1'b0;
                    rx_acc_d   = 1'b1;
                    if (last_q) begin
                        state_d = CS_HOLD;
                    end else begin
                        state_d = BYTE_DONE;
                    end
                end else if (!rx_valid_q) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                end else begin
                    rx_valid_d = 1'b1;
                end
            end
            CS_HOLD: begin
                if (cnt_q == CW'(CS_HOLD_CYCLES - 1)) begin
                    cs_d    = 1'b1;
                    state_d = CS_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CS_IDLE: begin
                if (cnt_q == CW'(CS_IDLE_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
            end
        endcase

        tx_ready_d = (state_d == IDLE) || ((state_d == BYTE_DONE) && rx_acc_d);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_acc_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            rx_acc_q   <= rx_acc_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign spi_cs   = cs_q;
    assign spi_sck  = sck_s;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: loopback and ADXL362 slave models, directed plus randomized byte streams.
module tb_spi_master;
    import spi_pkg::*;

    localparam int DIV   = 2;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int IDLEC = 4;
    localparam int LAT_FIRST = 1 + SETUP + 16 * DIV + 1;
    localparam int LAT_NEXT  = 16 * DIV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, busy;
    logic       spi_cs, spi_sck, spi_mosi, spi_miso;

    spi_master #(
        .CLK_DIV(DIV), .CS_SETUP_CYCLES(SETUP), .CS_HOLD_CYCLES(HOLD), .CS_IDLE_CYCLES(IDLEC)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave side: either a wire loopback or a byte-level ADXL362 register model
    logic       loopback = 1'b1;
    logic       slv_miso = 1'b0;
    logic       sck_prev = 1'b0;
    logic       cs_prev  = 1'b1;
    logic [7:0] slv_in = 8'h00, slv_out = 8'h00, slv_cmd = 8'h00, slv_addr = 8'h00;
    int         slv_bits = 0, slv_idx = 0;
    int         tog_cnt = 0, rise_cnt = 0, cs_rise_cnt = 0;
    logic [7:0] mosi_bytes[$];
    logic [7:0] regs[256];

    assign spi_miso = loopback ? spi_mosi : slv_miso;

    always @(negedge clk) begin
        if (spi_sck != sck_prev) tog_cnt++;
        if (spi_cs && !cs_prev) cs_rise_cnt++;
        if (!spi_cs && cs_prev) begin
            slv_bits = 0;
            slv_idx  = 0;
            slv_out  = 8'h00;
            slv_miso = 1'b0;
        end else if (!spi_cs && spi_sck && !sck_prev) begin
            rise_cnt++;
            slv_in = {slv_in[6:0], spi_mosi};
            slv_bits++;
            if (slv_bits == 8) begin
                mosi_bytes.push_back(slv_in);
                if (slv_idx == 0) slv_cmd = slv_in;
                else if (slv_idx == 1) slv_addr = slv_in;
                slv_idx++;
                slv_bits = 0;
                if (slv_idx >= 2 && slv_cmd == CMD_READ)
                    slv_out = regs[8'(slv_addr + 8'(slv_idx - 2))];
                else
                    slv_out = 8'h00;
            end
        end else if (!spi_cs && !spi_sck && sck_prev) begin
            slv_miso = slv_out[3'(7 - slv_bits)];
        end
        sck_prev = spi_sck;
        cs_prev  = spi_cs;
    end

    int n_chk = 0;
    int n_fail = 0;
    int acc_cyc = 0;
    int tog0 = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        tx_data  = b;
        tx_last  = last;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_accept_timeout", int'(n < 200), 1);
        @(negedge clk);
        tx_valid = 1'b0;
        acc_cyc  = cyc;
        tog0     = tog_cnt;
    endtask

    task automatic recv(input int stall, output logic [7:0] b, output int lat);
        int n, bad, t_snap;
        n = 0;
        bad = 0;
        while (!rx_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rx_valid_timeout", int'(n < 500), 1);
        lat = cyc - acc_cyc;
        b = rx_data;
        chk("sck_toggles_per_byte", tog_cnt - tog0, 16);
        t_snap = tog_cnt;
        for (int i = 0; i < stall; i++) begin
            if (spi_sck || spi_cs || tx_ready || !rx_valid || rx_data !== b) bad++;
            @(negedge clk);
        end
        chk("rx_stall_frozen", bad, 0);
        chk("rx_stall_no_toggle", tog_cnt - t_snap, 0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic gap_idle(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (spi_cs || spi_sck || !busy || !tx_ready) bad++;
        end
        chk("tx_gap_cs_low_sck_low", bad, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < 200), 1);
        chk("idle_tx_ready", tx_ready, 1);
        chk("idle_cs_high", spi_cs, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b, r;
        int lat, len, cs0, rise0, cs_hi, bad;

        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[REG_DEVID_AD] = DEVID_AD_VALUE;
        regs[1] = 8'h1D;
        regs[2] = 8'hF2;

        reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", spi_cs, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_tx_ready_after_rst", tx_ready, 1);

        // Single loopback byte: latency and cs release timing
        send(8'h5A, 1'b1);
        chk("busy_in_txn", busy, 1);
        chk("cs_low_in_txn", spi_cs, 0);
        recv(0, r, lat);
        chk("single_rx_data", r, 8'h5A);
        chk("single_latency", lat, LAT_FIRST);
        @(negedge clk);
        chk("cs_hold_1", spi_cs, 0);
        @(negedge clk);
        chk("cs_rise_after_hold", spi_cs, 1);
        chk("tx_ready_in_cs_idle", tx_ready, 0);
        wait_idle();

        // Two bytes with a 10-cycle rx stall after the first
        send(8'hC3, 1'b0);
        recv(10, r, lat);
        chk("stall_b0", r, 8'hC3);
        send(8'h3C, 1'b1);
        recv(0, r, lat);
        chk("stall_b1", r, 8'h3C);
        chk("stall_b1_latency", lat, LAT_NEXT);
        wait_idle();

        // Two bytes with a 7-cycle tx_valid gap
        cs0 = cs_rise_cnt;
        send(8'h81, 1'b0);
        recv(0, r, lat);
        chk("gap_b0", r, 8'h81);
        gap_idle(7);
        send(8'h7E, 1'b1);
        recv(0, r, lat);
        chk("gap_b1", r, 8'h7E);
        chk("gap_cs_stayed_low", cs_rise_cnt - cs0, 0);
        wait_idle();

        // Randomized loopback transactions
        for (int t = 0; t < 4; t++) begin
            len = $urandom_range(1, 4);
            cs0 = cs_rise_cnt;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                if (i > 0) gap_idle($urandom_range(0, 7));
                send(b, (i == len - 1));
                recv($urandom_range(0, 10), r, lat);
                chk("rand_rx_data", r, b);
                chk("rand_latency", lat, (i == 0) ? LAT_FIRST : LAT_NEXT);
            end
            chk("rand_cs_low_whole_txn", cs_rise_cnt - cs0, 0);
            wait_idle();
        end

        // ADXL362 DEVID_AD read
        loopback = 1'b0;
        mosi_bytes.delete();
        rise0 = rise_cnt;
        cs0 = cs_rise_cnt;
        send(CMD_READ, 1'b0);
        recv(0, r, lat);
        send(REG_DEVID_AD, 1'b0);
        recv(0, r, lat);
        send(8'hFF, 1'b1);
        recv(0, r, lat);
        chk("adxl_devid", r, regs[REG_DEVID_AD]);
        chk("adxl_sck_rises", rise_cnt - rise0, 24);
        chk("adxl_cs_low", cs_rise_cnt - cs0, 0);
        chk("adxl_mosi_count", mosi_bytes.size(), 3);
        if (mosi_bytes.size() == 3) begin
            chk("adxl_mosi_0", mosi_bytes[0], CMD_READ);
            chk("adxl_mosi_1", mosi_bytes[1], REG_DEVID_AD);
            chk("adxl_mosi_2", mosi_bytes[2], 8'hFF);
        end
        wait_idle();
        loopback = 1'b1;

        // Back-to-back single-byte transactions
        send(8'h96, 1'b1);
        recv(0, r, lat);
        chk("b2b_0", r, 8'h96);
        cs_hi = 0;
        bad = 0;
        for (int n = 0; n < 100 && !tx_ready; n++) begin
            @(negedge clk);
            if (spi_cs) cs_hi++;
            if (tx_ready && busy) bad++;
        end
        chk("b2b_tx_ready_low_hold_idle", bad, 0);
        send(8'h69, 1'b1);
        chk("b2b_cs_high_min", int'(cs_hi >= IDLEC), 1);
        recv(0, r, lat);
        chk("b2b_1", r, 8'h69);
        chk("b2b_1_latency", lat, LAT_FIRST);
        wait_idle();

        // Reset in the middle of shifting 0xA5
        send(8'hA5, 1'b1);
        repeat (8) @(negedge clk);
        chk("mid_shift_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_cs", spi_cs, 1);
        chk("mid_rst_sck", spi_sck, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_ready", tx_ready, 0);
        reset = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (rx_valid) bad++;
        end
        chk("mid_rst_no_rx_valid", bad, 0);
        chk("mid_rst_back_idle", tx_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
